// File: rtl/ofifo_bank_pkg.sv
// Shared sizing for the output FIFO bank: default geometry, pointer and entry widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofifo_bank_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    // One extra pointer bit separates "full" from "empty" when the addresses match.
    localparam int PTR_W   = $clog2(DEPTH_DEF) + 1;
    // Each stored entry is {zero_flag, psum}.
    localparam int ENTRY_W = PSUM_BW_DEF + 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column synchronous FIFO holding {zero_flag, psum} entries for one array column.
// Latency: dout shows the head combinationally; a write is visible at the head one edge later.
// Backpressure: writes to a full FIFO are dropped; reads of an empty FIFO are ignored.
module ofifo_col_fifo
    import ofifo_bank_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [psum_bw:0] din,
    output logic [psum_bw:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [psum_bw:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    // Fullness is judged on the pre-edge pointers, so a same-cycle read never rescues a write.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;
    assign dout  = mem[rptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally mod 2*DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PW'(1);
            if (do_rd) rptr <= rptr + PW'(1);
        end
    end

    // Storage array; no reset needed since pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_bank.sv
// Output FIFO bank: per-column FIFOs absorb skewed column valids and pop whole aligned rows.
// Latency: rd accepted at an edge -> out/out_zero/o_valid registered for the following cycle.
// Backpressure: rd honoured only while o_ready; writes into a full column are dropped and set sticky o_ovf.
module ofifo_bank
    import ofifo_bank_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         in_zero,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic [col-1:0]         out_zero,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_ovf
);

    logic [col-1:0]         col_empty;
    logic [col-1:0]         col_full;
    logic [psum_bw:0]       col_dout [col];
    logic [psum_bw*col-1:0] row_dat;
    logic [col-1:0]         row_zero;
    logic                   rd_acc;

    // A row pops only when every column has an entry, keeping rows intact.
    assign o_ready = &(~col_empty);
    assign o_full  = |col_full;
    assign rd_acc  = rd & o_ready;

    for (genvar c = 0; c < col; c++) begin : g_col
        ofifo_col_fifo #(
            .psum_bw (psum_bw),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .rd    (rd_acc),
            .din   ({in_zero[c], in[c*psum_bw +: psum_bw]}),
            .dout  (col_dout[c]),
            .empty (col_empty[c]),
            .full  (col_full[c])
        );

        assign row_dat[c*psum_bw +: psum_bw] = col_dout[c][psum_bw-1:0];
        assign row_zero[c]                   = col_dout[c][psum_bw];
    end

    // Registered output row; holds its last value when no row is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            out_zero <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= rd_acc;
            if (rd_acc) begin
                out      <= row_dat;
                out_zero <= row_zero;
            end
        end
    end

    // Sticky overflow: any strobe landing on a column that was full before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
        end else if (|(wr & col_full)) begin
            o_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo_bank.sv
module tb_ofifo_bank;

    localparam int COL = 8;
    localparam int BW  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW*COL-1:0]   in_dat;
    logic [COL-1:0]      in_zero;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [BW*COL-1:0]   out;
    logic [COL-1:0]      out_zero;
    logic                o_valid;
    logic                o_ready;
    logic                o_full;
    logic                o_ovf;

    int checks = 0;
    int errors = 0;

    ofifo_bank #(.col(COL), .psum_bw(BW), .DEPTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_dat),
        .in_zero  (in_zero),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .out_zero (out_zero),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_full   (o_full),
        .o_ovf    (o_ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW*COL-1:0] rep(input logic [BW-1:0] v);
        logic [BW*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [BW*COL-1:0] row_pat(input int r);
        logic [BW*COL-1:0] x;
        for (int c = 0; c < COL; c++) x[c*BW +: BW] = BW'(r * 16 + c);
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1; wr = '0; rd = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; in_dat = '0; in_zero = '0;
        step(); step();
        reset = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_ready); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (out !== '0 || out_zero !== '0) begin errors++; $display("FAIL reset_out got %h/%h want 0/0", out, out_zero); end
    endtask

    task automatic test_basic();
        wr = 8'hFF; in_zero = '0;
        in_dat = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        step();
        wr = '0;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", o_ready); end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", o_valid); end
        checks++; if (out !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("FAIL basic_out got %h", out); end
        checks++; if (out_zero !== 8'h00) begin errors++; $display("FAIL basic_zero got %h want 00", out_zero); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after got %b want 0", o_ready); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", o_valid); end
        checks++; if (out !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("FAIL basic_out_hold got %h", out); end
    endtask

    task automatic test_skew();
        logic [BW*COL-1:0] exp_row;
        for (int i = 0; i < COL; i++) begin
            wr = 8'(1 << i);
            in_dat = rep(BW'(100 + i));
            in_zero = (i % 2 == 1) ? 8'hFF : 8'h00;
            exp_row[i*BW +: BW] = BW'(100 + i);
            rd = (i == 3);
            step();
            checks++;
            if (o_ready !== (i == 7)) begin errors++; $display("FAIL skew_ready col %0d got %b want %b", i, o_ready, (i == 7)); end
            if (i == 3) begin
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_ignored_rd got valid %b want 0", o_valid); end
            end
        end
        wr = '0; rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b1 || out !== exp_row) begin errors++; $display("FAIL skew_row got %b/%h want 1/%h", o_valid, out, exp_row); end
        checks++; if (out_zero !== 8'hAA) begin errors++; $display("FAIL skew_zero got %h want aa", out_zero); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL skew_empty got %b want 0", o_ready); end
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 0; r < 64; r++) begin
            wr = 8'hFF; in_dat = row_pat(r); in_zero = 8'(r);
            step();
        end
        wr = '0;
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", o_full); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %b want 0", o_ovf); end
        wr = 8'hFF; in_dat = rep(16'hDEAD); in_zero = 8'hFF;
        step();
        wr = '0;
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", o_ovf); end
        rd = 1'b1;
        for (int r = 0; r < 64; r++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || out !== row_pat(r) || out_zero !== 8'(r)) begin
                errors++; $display("FAIL full_read row %0d got %b/%h/%h want 1/%h/%h", r, o_valid, out, out_zero, row_pat(r), 8'(r));
            end
        end
        rd = 1'b0;
        checks++; if (o_ready !== 1'b0 || o_full !== 1'b0) begin errors++; $display("FAIL full_drained got ready %b full %b want 0 0", o_ready, o_full); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky got %b want 1", o_ovf); end
    endtask

    task automatic test_full_simul();
        do_reset();
        in_zero = '0;
        for (int r = 0; r < 64; r++) begin
            wr = 8'hFF; in_dat = rep(BW'(r));
            step();
        end
        checks++; if (o_full !== 1'b1 || o_ovf !== 1'b0) begin errors++; $display("FAIL simul_pre got full %b ovf %b want 1 0", o_full, o_ovf); end
        wr = 8'hFF; rd = 1'b1; in_dat = rep(16'hBEEF);
        step();
        wr = '0;
        checks++; if (o_valid !== 1'b1 || out !== rep(16'd0)) begin errors++; $display("FAIL simul_pop got %b/%h want 1/row0", o_valid, out); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL simul_ovf got %b want 1", o_ovf); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL simul_full got %b want 0", o_full); end
        for (int r = 1; r < 64; r++) step();
        rd = 1'b0;
        checks++; if (out !== rep(16'd63)) begin errors++; $display("FAIL simul_last got %h want row 63", out); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL simul_dropped got ready %b want 0", o_ready); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        in_zero = '0;
        wr = 8'hFF; in_dat = rep(16'd3);
        step();
        wr = 8'hFF; in_dat = rep(16'd7); rd = 1'b1;
        step();
        wr = '0;
        checks++; if (o_valid !== 1'b1 || out !== rep(16'd3)) begin errors++; $display("FAIL same_old_head got %b/%h want 1/all 3", o_valid, out); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b want 1", o_ready); end
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b1 || out !== rep(16'd7)) begin errors++; $display("FAIL same_new got %b/%h want 1/all 7", o_valid, out); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL same_empty got %b want 0", o_ready); end
    endtask

    task automatic test_mid_reset();
        in_zero = '0;
        for (int r = 0; r < 10; r++) begin
            wr = 8'hFF; in_dat = rep(BW'(50 + r));
            step();
        end
        wr = '0; rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b1 || out !== rep(16'd50)) begin errors++; $display("FAIL mid_pre got %b/%h want 1/all 50", o_valid, out); end
        reset = 1'b1; wr = 8'hFF; rd = 1'b1; in_dat = rep(16'h1111);
        step();
        reset = 1'b0; wr = '0; rd = 1'b0;
        checks++; if (o_ready !== 1'b0 || o_full !== 1'b0 || o_ovf !== 1'b0) begin errors++; $display("FAIL mid_flags got ready %b full %b ovf %b want 0 0 0", o_ready, o_full, o_ovf); end
        checks++; if (out !== '0 || o_valid !== 1'b0) begin errors++; $display("FAIL mid_out got %h valid %b want 0 0", out, o_valid); end
        wr = 8'hFF; in_dat = rep(16'h55AA); in_zero = 8'hFF;
        step();
        wr = '0; rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b1 || out !== rep(16'h55AA) || out_zero !== 8'hFF) begin errors++; $display("FAIL mid_new got %b/%h/%h want 1/all 55aa/ff", o_valid, out, out_zero); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_only_new got ready %b want 0", o_ready); end
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; in_dat = '0; in_zero = '0;
        test_reset();
        test_basic();
        test_skew();
        test_full();
        test_full_simul();
        test_same_cycle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
